pe_ws_dbuf: RTL and testbench

Weight-stationary systolic processing element with parameterised data and accumulator widths, signed/unsigned arithmetic, and a double-buffered weight register. A new weight column shifts into a shadow register while the active weight keeps serving MACs, so compute does not stall for weight reload. Tiles into the systolic array in place of the single-buffer PE: activations flow horizontally, partial sums and weights flow vertically.

---
 rtl/pe_ws_dbuf_if.sv | 19 +
 rtl/pe_ws_dbuf.sv | 122 ++++++++++++
 tb/tb_pe_ws_dbuf.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_ws_dbuf_if.sv
// Link bundle between neighbouring weight-stationary PEs: weight shift and
// swap, activation and partial sum. A PE reads one bundle through the slave
// modport and drives the next one through the master modport, so a column or
// row of PEs chains by sharing one bundle between them.
interface pe_ws_dbuf_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  logic              w_vld;
  logic [DATA_W-1:0] w;
  logic              w_swap;
  logic              a_vld;
  logic [DATA_W-1:0] a;
  logic              ps_vld;
  logic [ACC_W-1:0]  ps;

  modport master (output w_vld, w, w_swap, a_vld, a, ps_vld, ps);
  modport slave  (input  w_vld, w, w_swap, a_vld, a, ps_vld, ps);
endinterface

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE with a double-buffered weight.
// A new weight shifts into the shadow register (ws) while the active weight
// (wa) keeps serving MACs; a swap pulse promotes ws to wa. Weight, swap and
// activation are forwarded with one cycle of latency per PE.
// Build option: define PE_SAT_EN to saturate the accumulate instead of
// wrapping modulo 2^ACC_W.
module pe_ws_dbuf #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  pe_ws_dbuf_if.slave  src,
  pe_ws_dbuf_if.master dst,
  output logic         err
);

  logic [DATA_W-1:0] wa;
  logic [DATA_W-1:0] ws;
  logic              sf;
  logic [ACC_W-1:0]  w_ext;
  logic [ACC_W-1:0]  a_ext;
  logic [ACC_W-1:0]  prod;
  logic [ACC_W-1:0]  mac;

  // Extend both operands to ACC_W so the low ACC_W bits of the product are the
  // correctly signed/zero-extended full product.
  always_comb begin
    w_ext = {{(ACC_W-DATA_W){SIGNED & wa[DATA_W-1]}}, wa};
    a_ext = {{(ACC_W-DATA_W){SIGNED & src.a[DATA_W-1]}}, src.a};
    prod  = w_ext * a_ext;
  end

`ifdef PE_SAT_EN
  logic [ACC_W:0] sum;

  // One guard bit above the accumulator reveals overflow, which is clamped.
  always_comb begin
    sum = {SIGNED & src.ps[ACC_W-1], src.ps} + {SIGNED & prod[ACC_W-1], prod};
    mac = sum[ACC_W-1:0];
    if (SIGNED) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        mac = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (sum[ACC_W]) begin
      mac = '1;
    end
  end
`else
  // Plain ACC_W-wide add, wrapping on overflow.
  always_comb begin
    mac = src.ps + prod;
  end
`endif

  // Shadow load and swap; a same-cycle swap takes the pre-write shadow value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wa <= '0;
      ws <= '0;
      sf <= 1'b0;
    end else begin
      if (src.w_vld) begin
        ws <= src.w;
      end
      if (src.w_swap && sf) begin
        wa <= ws;
      end
      if (src.w_vld) begin
        sf <= 1'b1;
      end else if (src.w_swap) begin
        sf <= 1'b0;
      end
    end
  end

  // Push the displaced shadow weight and the swap pulse to the PE below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst.w_vld  <= 1'b0;
      dst.w      <= '0;
      dst.w_swap <= 1'b0;
    end else begin
      dst.w_vld  <= src.w_vld & sf;
      dst.w_swap <= src.w_swap;
      if (src.w_vld && sf) begin
        dst.w <= ws;
      end
    end
  end

  // Forward the activation to the right; data holds while invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst.a_vld <= 1'b0;
      dst.a     <= '0;
    end else begin
      dst.a_vld <= src.a_vld;
      if (src.a_vld) begin
        dst.a <= src.a;
      end
    end
  end

  // MAC with the pre-swap active weight; valid disagreement sets sticky err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst.ps_vld <= 1'b0;
      dst.ps     <= '0;
      err        <= 1'b0;
    end else begin
      dst.ps_vld <= src.a_vld & src.ps_vld;
      if (src.a_vld != src.ps_vld) begin
        err <= 1'b1;
      end else if (src.a_vld) begin
        dst.ps <= mac;
      end
    end
  end

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Bench for pe_ws_dbuf: a signed 8/16 PE, an unsigned 8/32 PE and a chain of
// two signed 8/16 PEs, all fed the same top-level stimulus and compared every
// cycle against a behavioural model computed with integer arithmetic.
module tb_pe_ws_dbuf;

  typedef struct {
    bit     w_vld;
    longint w;
    bit     swap;
    bit     a_vld;
    longint a;
    bit     ps_vld;
    longint ps;
  } in_t;

  typedef struct {
    longint wa;
    longint ws;
    bit     sf;
    bit     w_vld;
    longint w;
    bit     swap;
    bit     a_vld;
    longint a;
    bit     ps_vld;
    longint ps;
    bit     err;
  } pe_t;

  logic clk = 1'b0;
  logic reset;
  logic s_err, u_err, ct_err, cb_err;
  int   n_checks = 0;
  int   n_fail   = 0;

  pe_t    m [4];
  pe_t    zero_pe;
  int     accw [4] = '{16, 32, 16, 16};
  bit     sgn  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  longint sat_exp;

  always #5 clk = ~clk;

  pe_ws_dbuf_if #(.DATA_W(8), .ACC_W(16)) s_src ();
  pe_ws_dbuf_if #(.DATA_W(8), .ACC_W(16)) s_dst ();
  pe_ws_dbuf_if #(.DATA_W(8), .ACC_W(32)) u_src ();
  pe_ws_dbuf_if #(.DATA_W(8), .ACC_W(32)) u_dst ();
  pe_ws_dbuf_if #(.DATA_W(8), .ACC_W(16)) c_src ();
  pe_ws_dbuf_if #(.DATA_W(8), .ACC_W(16)) c_mid ();
  pe_ws_dbuf_if #(.DATA_W(8), .ACC_W(16)) c_dst ();

  pe_ws_dbuf #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset), .src(s_src), .dst(s_dst), .err(s_err));
  pe_ws_dbuf #(.DATA_W(8), .ACC_W(32), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .src(u_src), .dst(u_dst), .err(u_err));
  pe_ws_dbuf #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1)) dut_ct (
    .clk(clk), .reset(reset), .src(c_src), .dst(c_mid), .err(ct_err));
  pe_ws_dbuf #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1)) dut_cb (
    .clk(clk), .reset(reset), .src(c_mid), .dst(c_dst), .err(cb_err));

  function automatic in_t mk(bit wv, longint w, bit sw, bit av, longint a, bit pv, longint ps);
    in_t r;
    r.w_vld = wv; r.w = w; r.swap = sw;
    r.a_vld = av; r.a = a; r.ps_vld = pv; r.ps = ps;
    return r;
  endfunction

  // Interpret the low 'bits' bits of v as a signed or unsigned integer.
  function automatic longint as_int(longint v, int bits, bit sg);
    longint r = v & ((longint'(1) << bits) - 1);
    if (sg && ((r >> (bits - 1)) & 1) == 1) r = r - (longint'(1) << bits);
    return r;
  endfunction

  // Reference accumulate: exact integer sum, then clamp or wrap to ACC_W bits.
  function automatic longint mac_ref(longint wa, longint a, longint ps, int aw, bit sg);
    longint r = as_int(ps, aw, sg) + as_int(wa, 8, sg) * as_int(a, 8, sg);
`ifdef PE_SAT_EN
    longint lo = sg ? -(longint'(1) << (aw - 1)) : 0;
    longint hi = sg ? (longint'(1) << (aw - 1)) - 1 : (longint'(1) << aw) - 1;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`endif
    return r & ((longint'(1) << aw) - 1);
  endfunction

  function automatic pe_t pe_step(pe_t s, in_t i, int k);
    pe_t    n   = s;
    longint msk = (longint'(1) << accw[k]) - 1;
    n.w_vld = 1'b0;
    if (i.w_vld) begin
      n.ws = i.w & 255;
      n.sf = 1'b1;
      if (s.sf) begin
        n.w     = s.ws;
        n.w_vld = 1'b1;
      end
    end
    n.swap = i.swap;
    if (i.swap && s.sf) begin
      n.wa = s.ws;
      if (!i.w_vld) n.sf = 1'b0;
    end
    n.a_vld = i.a_vld;
    if (i.a_vld) n.a = i.a & 255;
    n.ps_vld = 1'b0;
    if (i.a_vld != i.ps_vld) n.err = 1'b1;
    else if (i.a_vld) begin
      n.ps     = mac_ref(s.wa, i.a & 255, i.ps & msk, accw[k], sgn[k]);
      n.ps_vld = 1'b1;
    end
    return n;
  endfunction

  task automatic step_model(in_t i);
    pe_t top_old = m[2];
    m[0] = pe_step(m[0], i, 0);
    m[1] = pe_step(m[1], i, 1);
    m[2] = pe_step(m[2], i, 2);
    m[3] = pe_step(m[3], mk(top_old.w_vld, top_old.w, top_old.swap, top_old.a_vld,
                            top_old.a, top_old.ps_vld, top_old.ps), 3);
  endtask

  task automatic model_reset();
    foreach (m[k]) m[k] = zero_pe;
  endtask

  task automatic checkOutput(string tag, logic [63:0] observed, longint expected);
    n_checks++;
    if (observed !== 64'(expected)) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkPe(string n, int k, logic [63:0] wv, logic [63:0] w, logic [63:0] sw,
                         logic [63:0] av, logic [63:0] a, logic [63:0] pv,
                         logic [63:0] ps, logic [63:0] e);
    checkOutput({n, ".w_vld"},  wv, longint'(m[k].w_vld));
    checkOutput({n, ".w"},      w,  m[k].w);
    checkOutput({n, ".swap"},   sw, longint'(m[k].swap));
    checkOutput({n, ".a_vld"},  av, longint'(m[k].a_vld));
    checkOutput({n, ".a"},      a,  m[k].a);
    checkOutput({n, ".ps_vld"}, pv, longint'(m[k].ps_vld));
    checkOutput({n, ".ps"},     ps, m[k].ps);
    checkOutput({n, ".err"},    e,  longint'(m[k].err));
  endtask

  task automatic checkAll();
    checkPe("s", 0, 64'(s_dst.w_vld), 64'(s_dst.w), 64'(s_dst.w_swap), 64'(s_dst.a_vld),
            64'(s_dst.a), 64'(s_dst.ps_vld), 64'(s_dst.ps), 64'(s_err));
    checkPe("u", 1, 64'(u_dst.w_vld), 64'(u_dst.w), 64'(u_dst.w_swap), 64'(u_dst.a_vld),
            64'(u_dst.a), 64'(u_dst.ps_vld), 64'(u_dst.ps), 64'(u_err));
    checkPe("ct", 2, 64'(c_mid.w_vld), 64'(c_mid.w), 64'(c_mid.w_swap), 64'(c_mid.a_vld),
            64'(c_mid.a), 64'(c_mid.ps_vld), 64'(c_mid.ps), 64'(ct_err));
    checkPe("cb", 3, 64'(c_dst.w_vld), 64'(c_dst.w), 64'(c_dst.w_swap), 64'(c_dst.a_vld),
            64'(c_dst.a), 64'(c_dst.ps_vld), 64'(c_dst.ps), 64'(cb_err));
  endtask

  task automatic drive(in_t i);
    s_src.w_vld = i.w_vld; s_src.w = i.w[7:0]; s_src.w_swap = i.swap;
    s_src.a_vld = i.a_vld; s_src.a = i.a[7:0]; s_src.ps_vld = i.ps_vld; s_src.ps = i.ps[15:0];
    u_src.w_vld = i.w_vld; u_src.w = i.w[7:0]; u_src.w_swap = i.swap;
    u_src.a_vld = i.a_vld; u_src.a = i.a[7:0]; u_src.ps_vld = i.ps_vld; u_src.ps = i.ps[31:0];
    c_src.w_vld = i.w_vld; c_src.w = i.w[7:0]; c_src.w_swap = i.swap;
    c_src.a_vld = i.a_vld; c_src.a = i.a[7:0]; c_src.ps_vld = i.ps_vld; c_src.ps = i.ps[15:0];
  endtask

  // Drive one cycle of inputs at the falling edge, clock it, check at the next falling edge.
  task automatic applyStimulus(in_t i);
    drive(i);
    step_model(i);
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  // Assert reset between clock edges and check that every output clears at once.
  task automatic asyncReset();
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    #2 reset = 1'b1;
    #1 model_reset();
    checkAll();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    in_t idle = mk(0, 0, 0, 0, 0, 0, 0);
    in_t mac1 = mk(0, 0, 0, 1, 1, 1, 0);

    reset = 1'b1;
    drive(idle);
    model_reset();
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    checkAll();
    reset = 1'b0;

    $display("[TB] MAC with unloaded weight");
    applyStimulus(mk(0, 0, 0, 1, 3, 1, 5));
    checkOutput("t1_ps_s", 64'(s_dst.ps), 5);
    checkOutput("t1_vld_s", 64'(s_dst.ps_vld), 1);

    $display("[TB] signed and unsigned weight 0xFE");
    applyStimulus(mk(1, 'hFE, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 1, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 1, 7, 1, 100));
    checkOutput("t2_ps_signed", 64'(s_dst.ps), 86);
    checkOutput("t2_ps_unsigned", 64'(u_dst.ps), 1878);

    $display("[TB] double buffering");
    applyStimulus(mk(1, 3, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 1, 0, 0, 0, 0));
    applyStimulus(mk(1, 9, 0, 1, 1, 1, 0));
    checkOutput("t3_ps_load", 64'(s_dst.ps), 3);
    applyStimulus(mac1);
    checkOutput("t3_ps_hold", 64'(s_dst.ps), 3);
    applyStimulus(mk(0, 0, 1, 1, 1, 1, 0));
    checkOutput("t3_ps_swap_edge", 64'(s_dst.ps), 3);
    applyStimulus(mac1);
    checkOutput("t3_ps_after_swap", 64'(s_dst.ps), 9);

    $display("[TB] two-PE shift chain");
    applyStimulus(mk(1, 4, 0, 0, 0, 0, 0));
    applyStimulus(mk(1, 6, 0, 0, 0, 0, 0));
    checkOutput("t4_fwd_vld", 64'(c_mid.w_vld), 1);
    checkOutput("t4_fwd_w", 64'(c_mid.w), 4);
    applyStimulus(idle);
    applyStimulus(mk(0, 0, 1, 0, 0, 0, 0));
    checkOutput("t4_swap_fwd", 64'(c_mid.w_swap), 1);
    applyStimulus(mac1);
    checkOutput("t4_upper_ps", 64'(c_mid.ps), 6);
    applyStimulus(idle);
    checkOutput("t4_lower_ps", 64'(c_dst.ps), 10);

    $display("[TB] accumulate overflow");
    applyStimulus(mk(1, 1, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 1, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 1, 1, 1, 32767));
`ifdef PE_SAT_EN
    sat_exp = 32767;
`else
    sat_exp = 'h8000;
`endif
    checkOutput("t5_overflow", 64'(s_dst.ps), sat_exp);

    $display("[TB] valid mismatch");
    applyStimulus(mk(0, 0, 0, 1, 5, 0, 123));
    checkOutput("t6_ps_vld", 64'(s_dst.ps_vld), 0);
    checkOutput("t6_ps_hold", 64'(s_dst.ps), sat_exp);
    checkOutput("t6_a_vld", 64'(s_dst.a_vld), 1);
    checkOutput("t6_err", 64'(s_err), 1);
    repeat (3) applyStimulus(idle);
    checkOutput("t6_err_sticky", 64'(s_err), 1);

    $display("[TB] asynchronous reset mid-operation");
    asyncReset();
    checkOutput("t7_err_clear", 64'(s_err), 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      bit av;
      if (c == 200) asyncReset();
      av = ($urandom % 2) == 1;
      applyStimulus(mk(($urandom % 3) == 0, longint'($urandom % 256), ($urandom % 8) == 0,
                       av, longint'($urandom % 256),
                       (($urandom % 16) == 0) ? !av : av, longint'($urandom)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
